// File: rtl/mpresult_unloader.sv
// rtl/mpresult_unloader.sv - captures a wide mpadder result and streams it LSW-first as 32-bit words
module mpresult_unloader #(
    parameter int DATA_W = 1028,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              overrun
);

    localparam int NWORDS = (DATA_W + WORD_W - 1) / WORD_W;
    localparam int SH_W   = NWORDS * WORD_W;
    localparam int CNT_W  = $clog2(NWORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SH_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             overrun_q, overrun_d;

    logic capture;
    logic handshake;

    // A new result may be taken while idle, or on the very handshake that retires the final word.
    assign in_ready  = (state_q == IDLE) || (state_q == SEND && out_last_q && out_ready);
    assign capture   = in_valid && in_ready;
    assign handshake = out_valid_q && out_ready;

    assign out_data  = shreg_q[WORD_W-1:0];
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign overrun   = overrun_q;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        overrun_d   = overrun_q || (in_valid && !in_ready);

        if (capture) begin
            state_d     = SEND;
            shreg_d     = SH_W'(in_result);
            cnt_d       = '0;
            out_valid_d = 1'b1;
            out_last_d  = (LAST_CNT == '0);
        end else if (handshake) begin
            if (cnt_q == LAST_CNT) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end else begin
                shreg_d    = shreg_q >> WORD_W;
                cnt_d      = cnt_q + CNT_W'(1);
                out_last_d = ((cnt_q + CNT_W'(1)) == LAST_CNT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            overrun_q   <= overrun_d;
        end
    end

endmodule
